// File: rtl/audio_adc_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_adc_rx_pkg
//  Description : Shared audio codec constants: ADC receive FSM encoding,
//                default sample widths and DAC-side framing constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_adc_rx_pkg;

    // Default bits per channel for both codec directions
    localparam int c_AUDIO_DATA_WIDTH = 32;

    // ADC receive FSM encoding
    localparam int         c_ST_W     = 2;
    localparam logic [1:0] c_ST_SYNC  = 2'd0;
    localparam logic [1:0] c_ST_DELAY = 2'd1;
    localparam logic [1:0] c_ST_SHIFT = 2'd2;
    localparam logic [1:0] c_ST_WAIT  = 2'd3;

    // DAC-side constants (transmit path lives elsewhere)
    localparam int c_DAC_DATA_WIDTH = c_AUDIO_DATA_WIDTH;
    localparam int c_DAC_BCLK_DIV   = 16;
    localparam int c_DAC_SLOT_BITS  = 32;

endpackage
`default_nettype wire

// File: rtl/audio_adc_rx_sync_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_detect
//  Description : Multi-flop synchronizer for one asynchronous codec input,
//                followed by rise/fall detection against a delayed copy.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect
    import audio_adc_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Synchronizer chain plus one extra flop holding the previous level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  =  o_level & ~r_prev;
    assign o_fall  = ~o_level &  r_prev;

endmodule
`default_nettype wire

// File: rtl/audio_adc_rx.sv
`default_nettype none
// ============================================================================
//  Module      : audio_adc_rx
//  Description : I2S ADC receiver. Synchronizes the codec bit clock, word
//                clock and data, deserializes left/right words and presents
//                stereo pairs with a valid/ready handshake and overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_adc_rx
    import audio_adc_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = c_AUDIO_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  aud_bclk,
    input  logic                  aud_adclrck,
    input  logic                  aud_adcdat,
    output logic [DATA_WIDTH-1:0] left_out,
    output logic [DATA_WIDTH-1:0] right_out,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  overrun
);

    localparam int                 c_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_WIDTH - 1);

    logic w_brise, w_bclk_level, w_bclk_fall;
    logic w_lr_level, w_lr_rise, w_lr_fall, w_lr_edge;
    logic w_dat;
    logic [1:0] w_unused_bclk;

    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic [c_ST_W-1:0]      r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic [DATA_WIDTH-1:0]  r_left_hold;
    logic                   r_chan;
    logic                   r_have_left;

    logic [DATA_WIDTH-1:0]  r_left_out, r_right_out;
    logic                   r_valid, r_overrun;

    logic [DATA_WIDTH-1:0]  w_shift_next;
    logic [DATA_WIDTH-1:0]  w_word;
    logic                   w_close;
    logic                   w_pair_done;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk     (clk),
        .rst     (reset),
        .i_async (aud_bclk),
        .o_level (w_bclk_level),
        .o_rise  (w_brise),
        .o_fall  (w_bclk_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_lrck_sync (
        .clk     (clk),
        .rst     (reset),
        .i_async (aud_adclrck),
        .o_level (w_lr_level),
        .o_rise  (w_lr_rise),
        .o_fall  (w_lr_fall)
    );

    assign w_unused_bclk = {w_bclk_level, w_bclk_fall};
    assign w_lr_edge     = w_lr_rise | w_lr_fall;

    // Data needs only a synchronizer; same depth keeps it aligned with bclk
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dat_sync <= '0;
        end else begin
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], aud_adcdat};
        end
    end

    assign w_dat = r_dat_sync[SYNC_STAGES-1];

    // Word close detection: either the last bit arrives or lrck moves first
    always_comb begin
        w_shift_next = r_shift | ({{(DATA_WIDTH-1){1'b0}}, w_dat} << (c_LAST - r_cnt));
        w_close      = 1'b0;
        w_word       = r_shift;
        if (r_state == c_ST_SHIFT) begin
            if (w_lr_edge) begin
                w_close = 1'b1;
            end else if (w_brise && (r_cnt == c_LAST)) begin
                w_close = 1'b1;
                w_word  = w_shift_next;
            end
        end
    end

    assign w_pair_done = w_close & r_chan & r_have_left;

    // Framing FSM: lock on lrck fall, skip the I2S delay bit, shift MSB first
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_SYNC;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_chan      <= 1'b0;
            r_left_hold <= '0;
            r_have_left <= 1'b0;
        end else begin
            case (r_state)
                c_ST_SYNC: begin
                    if (w_lr_fall) begin
                        r_state <= c_ST_DELAY;
                    end
                end
                c_ST_DELAY: begin
                    if (w_brise) begin
                        r_state <= c_ST_SHIFT;
                        r_cnt   <= '0;
                        r_shift <= '0;
                        r_chan  <= w_lr_level;
                    end
                end
                c_ST_SHIFT: begin
                    if (w_lr_edge) begin
                        r_state <= c_ST_DELAY;
                    end else if (w_brise) begin
                        r_shift <= w_shift_next;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST) begin
                            r_state <= c_ST_WAIT;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (w_lr_edge) begin
                        r_state <= c_ST_DELAY;
                    end
                end
                default: r_state <= c_ST_SYNC;
            endcase

            if (w_close) begin
                if (!r_chan) begin
                    r_left_hold <= w_word;
                    r_have_left <= 1'b1;
                end else begin
                    r_have_left <= 1'b0;
                end
            end
        end
    end

    // Output holding stage: load on pair completion unless the consumer stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            r_left_out  <= '0;
            r_right_out <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_pair_done) begin
            if (r_valid && !sample_ready) begin
                r_overrun <= 1'b1;
            end else begin
                r_left_out  <= r_left_hold;
                r_right_out <= w_word;
                r_valid     <= 1'b1;
            end
        end else if (r_valid && sample_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign left_out     = r_left_out;
    assign right_out    = r_right_out;
    assign sample_valid = r_valid;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: doc/audio_adc_rx.md
AUDIO_ADC_RX -- requirements
Module: audio_adc_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the bits captured per channel (2..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer flops per codec input (>=2).
REQ-003 clk  input  1  system clock (50 MHz); all logic SHALL be synchronous to its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 aud_bclk  input  1  codec bit clock (asynchronous to clk, at most clk/8).
REQ-006 aud_adclrck  input  1  codec ADC word clock; low = left, high = right.
REQ-007 aud_adcdat  input  1  codec ADC serial data, MSB first.
REQ-008 left_out  output  DATA_WIDTH  held left sample.
REQ-009 right_out  output  DATA_WIDTH  held right sample.
REQ-010 sample_valid  output  1  held stereo pair is valid.
REQ-011 sample_ready  input  1  consumer accepts the pair.
REQ-012 overrun  output  1  sticky flag: a complete pair was dropped.

Function
REQ-013 SHALL pass aud_bclk, aud_adclrck and aud_adcdat each through SYNC_STAGES flops, then detect bclk rise and lrck edges by comparison with a one-cycle-delayed copy.
REQ-014 SHALL sample synchronized aud_adcdat and aud_adclrck only on cycles where a bclk rise is detected.
REQ-015 SHALL use I2S framing: the first data bit (MSB) of a word is on the second bclk rise after an lrck transition.
REQ-016 SHALL implement FSM states SYNC, DELAY, SHIFT, WAIT.
REQ-017 SYNC: SHALL leave only on an lrck falling edge, going to DELAY, so the first captured word is always left.
REQ-018 DELAY: SHALL skip one bclk rise, then go to SHIFT with bit counter 0 and the channel taken from the lrck level.
REQ-019 SHIFT: SHALL shift one bit into the channel shift register per bclk rise, MSB first.
REQ-019a SHIFT: after DATA_WIDTH bits it SHALL go to WAIT; on an lrck edge first, it SHALL close the word with its unfilled LSBs zero.
REQ-020 WAIT: SHALL ignore extra data bits and go to DELAY on the next lrck edge.
REQ-021 Left word close SHALL store it in an internal left holding register; right word close SHALL complete the pair.
REQ-022 Pair completion SHALL load left_out/right_out and set sample_valid on the following clk cycle, i.e. 1 clk after the last bit's bclk rise is detected.
REQ-023 sample_valid SHALL stay high, outputs stable, until a cycle with sample_valid && sample_ready; it SHALL clear the next cycle if no new pair arrives.
REQ-024 Pair completion while sample_valid=1 and sample_ready=0 SHALL drop the new pair, keep the held pair and set overrun.
REQ-025 Pair completion in the same cycle as an accepting handshake SHALL load the new pair, keep sample_valid=1 and leave overrun unchanged.
REQ-026 overrun SHALL stay set until reset.
REQ-027 A right word without a preceding left word in the current frame SHALL be discarded.

Reset
REQ-028 reset SHALL force the FSM to SYNC, clear the counters and shift and holding registers, and set sync flops to 0.
REQ-029 reset SHALL drive left_out=0, right_out=0, sample_valid=0 and overrun=0 on the next clk edge.
REQ-030 reset mid-word SHALL abandon the partial frame; capture SHALL resume only after a fresh lrck falling edge.

Structure
REQ-031 The FSM state encoding and default DATA_WIDTH SHALL live in a shared audio package with the DAC-side constants.
REQ-032 The per-input synchronizer plus edge detector SHALL be a sub-module, sync_edge_detect, instantiated for bclk and lrck; data uses its synchronizer only.

Verification
REQ-033 Two frames at bclk=clk/16, DATA_WIDTH=32, left=32'hA5A5_0001, right=32'h5A5A_8000, sample_ready=1 -> one valid pulse per frame with exactly those values.
REQ-034 DATA_WIDTH=32, codec frame of 24 bits per channel, left=24'h123456 -> left_out=32'h1234_5600.
REQ-035 sample_ready=0 across 2 frames -> the first pair is held, overrun=1 after the second pair, outputs unchanged.
REQ-036 sample_ready pulsed in the exact cycle a new pair completes -> the new pair is loaded, sample_valid stays 1, overrun=0.
REQ-037 Stimulus starts with lrck high (mid right word) -> no output until the first full left+right frame after the lrck falling edge.
REQ-038 reset asserted at bit 10 of a left word -> all outputs 0 next cycle; the next complete frame is received correctly.
